// File: rtl/remote_dac_driver.sv
// Streams four 8-bit stick levels round-robin to a quad serial DAC as 16-bit SPI frames.
// Channel 0 carries either the initialization-stage level or the gesture throttle.
module remote_dac_driver #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       on_state,
  input  logic [7:0] initial_signal,
  input  logic [7:0] throttle,
  input  logic [7:0] yaw,
  input  logic [7:0] pitch,
  input  logic [7:0] roll,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  channel;
  logic [15:0] shreg;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  ch_data;
  logic [15:0] load_word;

  // Frame layout: channel address, two control bits, data, four pad bits.
  always_comb begin
    ch_data = throttle;
    case (channel)
      2'd0:    ch_data = on_state ? initial_signal : throttle;
      2'd1:    ch_data = yaw;
      2'd2:    ch_data = pitch;
      default: ch_data = roll;
    endcase
    load_word = {channel, 2'b11, ch_data, 4'b0000};
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      channel    <= 2'd0;
      shreg      <= 16'd0;
      div_cnt    <= 16'd0;
      gap_cnt    <= 16'd0;
      bit_cnt    <= 4'd0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg    <= load_word;
          dac_din  <= load_word[15];
          dac_cs_n <= 1'b0;
          dac_sclk <= 1'b0;
          div_cnt  <= 16'd0;
          bit_cnt  <= 4'd0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 16'd0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else if (bit_cnt == 4'd15) begin
              // Last high phase ends: SCLK falls and CS releases on the same edge.
              dac_sclk   <= 1'b0;
              dac_cs_n   <= 1'b1;
              dac_din    <= 1'b0;
              gap_cnt    <= 16'd0;
              frame_done <= 1'b1;
              channel    <= channel + 2'd1;
              state      <= GAP;
            end else begin
              dac_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 4'd1;
              shreg    <= {shreg[14:0], 1'b0};
              dac_din  <= shreg[14];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            state <= enable ? LOAD : IDLE;
            busy  <= enable;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remote_dac_driver.sv
// Directed bench for remote_dac_driver: an SPI monitor reassembles each frame and the
// scenario tasks compare words, bit counts, CS widths and pacing against hand-computed values.
module tb_remote_dac_driver;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       on_state;
  logic [7:0] initial_signal;
  logic [7:0] throttle;
  logic [7:0] yaw;
  logic [7:0] pitch;
  logic [7:0] roll;
  logic       dac_cs_n;
  logic       dac_sclk;
  logic       dac_din;
  logic       busy;
  logic       frame_done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cap_w[$];
  int          cap_b[$];
  int          cap_l[$];
  int          fd_q[$];

  remote_dac_driver #(.CLK_DIV(4), .GAP_CYCLES(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .on_state       (on_state),
    .initial_signal (initial_signal),
    .throttle       (throttle),
    .yaw            (yaw),
    .pitch          (pitch),
    .roll           (roll),
    .dac_cs_n       (dac_cs_n),
    .dac_sclk       (dac_sclk),
    .dac_din        (dac_din),
    .busy           (busy),
    .frame_done     (frame_done),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SPI monitor: samples on the falling system clock edge
  int          cyc = 0;
  logic [15:0] m_word;
  int          m_bits;
  int          m_low;
  logic        prev_sclk;
  logic        prev_cs;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_word = 16'd0; m_bits = 0; m_low = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
    end else begin
      if (!dac_cs_n) m_low++;
      if (dac_sclk && !prev_sclk) begin
        m_word = {m_word[14:0], dac_din};
        m_bits++;
      end
      if (dac_cs_n && !prev_cs) begin
        cap_w.push_back(m_word); cap_b.push_back(m_bits); cap_l.push_back(m_low);
        m_word = 16'd0; m_bits = 0; m_low = 0;
      end
      if (frame_done) fd_q.push_back(cyc);
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
    end
  end

  // Driver tasks
  task automatic wait_word(output logic [15:0] w, output int b, output int l, output bit ok);
    int t = 0;
    while (cap_w.size() == 0 && t < 600) begin @(negedge clock); t++; end
    ok = (cap_w.size() != 0);
    if (ok) begin
      w = cap_w.pop_front(); b = cap_b.pop_front(); l = cap_l.pop_front();
    end else begin
      w = 16'hxxxx; b = 0; l = 0;
    end
  endtask

  task automatic wait_cs(input logic level, output bit ok);
    int t = 0;
    while (dac_cs_n !== level && t < 600) begin @(negedge clock); t++; end
    ok = (dac_cs_n === level);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; on_state = 1'b1;
    initial_signal = 8'hA5; throttle = 8'h00; yaw = 8'h12; pitch = 8'h80; roll = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if ({dac_cs_n, dac_sclk, dac_din, busy, frame_done} !== 5'b10000) begin
        n_fails++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 10000", i,
                 {dac_cs_n, dac_sclk, dac_din, busy, frame_done});
      end
    end
  endtask

  task automatic test_init_frame();
    logic [15:0] w; int b, l; bit ok;
    cap_w.delete(); cap_b.delete(); cap_l.delete(); fd_q.delete();
    reset_n = 1'b1;
    @(negedge clock);  // LOAD cycle
    n_checks++;
    if ({busy, dac_cs_n} !== 2'b11) begin
      n_fails++; $display("FAIL load_cycle busy/cs_n: got %b expected 11", {busy, dac_cs_n});
    end
    @(negedge clock);  // first SHIFT cycle
    n_checks++;
    if ({dac_cs_n, dac_sclk, dac_din} !== 3'b000) begin
      n_fails++; $display("FAIL first_bit cs_n/sclk/din: got %b expected 000", {dac_cs_n, dac_sclk, dac_din});
    end
    wait_word(w, b, l, ok);
    n_checks++;
    if (!ok || w !== 16'h3A50) begin
      n_fails++; $display("FAIL init_word: got %h expected 3a50", w);
    end
    n_checks++;
    if (b !== 16) begin n_fails++; $display("FAIL init_sclk_rises: got %0d expected 16", b); end
    n_checks++;
    if (l !== 128) begin n_fails++; $display("FAIL init_cs_low: got %0d expected 128", l); end
  endtask

  task automatic test_round_robin();
    logic [15:0] w, e; int b, l; bit ok;
    exp_q.push_back(16'h7120); exp_q.push_back(16'hB800); exp_q.push_back(16'hFFF0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_word(w, b, l, ok);
      n_checks++;
      if (!ok || w !== e || b !== 16) begin
        n_fails++; $display("FAIL rr_word: got %h/%0d bits expected %h/16", w, b, e);
      end
    end
    // Wrap back to channel 0, with initial_signal disturbed mid-shift
    wait_cs(1'b0, ok);
    repeat (40) @(negedge clock);
    initial_signal = 8'h5A;
    wait_word(w, b, l, ok);
    n_checks++;
    if (!ok || w !== 16'h3A50) begin
      n_fails++; $display("FAIL wrap_inflight_word: got %h expected 3a50", w);
    end
    initial_signal = 8'hA5;
    n_checks++;
    if (fd_q.size() !== 5) begin
      n_fails++; $display("FAIL frame_done_count: got %0d expected 5", fd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (fd_q[i+1] - fd_q[i] !== 145) begin
          n_fails++; $display("FAIL frame_done_period %0d: got %0d expected 145", i, fd_q[i+1] - fd_q[i]);
        end
      end
    end
  endtask

  task automatic test_throttle_switch();
    logic [15:0] w, e; int b, l; bit ok;
    on_state = 1'b0; throttle = 8'h40;
    exp_q.push_back(16'h7120); exp_q.push_back(16'hB800);
    exp_q.push_back(16'hFFF0); exp_q.push_back(16'h3400);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_word(w, b, l, ok);
      n_checks++;
      if (!ok || w !== e) begin
        n_fails++; $display("FAIL throttle_seq_word: got %h expected %h", w, e);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [15:0] w; int b, l, nbusy, bad; bit ok;
    wait_cs(1'b0, ok);
    repeat (10) @(negedge clock);
    enable = 1'b0;
    wait_cs(1'b1, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL drop_cs_release: got timeout expected cs_n high"); end
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin nbusy++; @(negedge clock); end
    n_checks++;
    if (nbusy !== 16) begin n_fails++; $display("FAIL drop_gap_len: got %0d expected 16", nbusy); end
    wait_word(w, b, l, ok);
    n_checks++;
    if (!ok || w !== 16'h7120 || b !== 16 || l !== 128) begin
      n_fails++; $display("FAIL drop_frame: got %h/%0d/%0d expected 7120/16/128", w, b, l);
    end
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (dac_cs_n !== 1'b1 || busy !== 1'b0 || dac_sclk !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || cap_w.size() !== 0) begin
      n_fails++; $display("FAIL idle_hold: got %0d active cycles expected 0", bad);
    end
    enable = 1'b1;
    wait_word(w, b, l, ok);
    n_checks++;
    if (!ok || w !== 16'hB800) begin
      n_fails++; $display("FAIL reenable_word: got %h expected b800", w);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w; int b, l; bit ok;
    wait_cs(1'b0, ok);
    repeat (66) @(negedge clock);  // bit 7 in progress
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({dac_cs_n, dac_sclk, busy} !== 3'b100) begin
      n_fails++; $display("FAIL reset_abort cs_n/sclk/busy: got %b expected 100", {dac_cs_n, dac_sclk, busy});
    end
    repeat (3) @(negedge clock);
    on_state = 1'b1;
    cap_w.delete(); cap_b.delete(); cap_l.delete();
    reset_n = 1'b1;
    wait_word(w, b, l, ok);
    n_checks++;
    if (!ok || w !== 16'h3A50 || b !== 16) begin
      n_fails++; $display("FAIL post_reset_word: got %h/%0d expected 3a50/16", w, b);
    end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_round_robin();
    test_throttle_switch();
    test_enable_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
